mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Sequencing controller between the ARM pipeline's MEM stage and an off-chip 16-bit asynchronous SRAM. It accepts one 32-bit read or write per request, splits it into two timed halfword accesses, and holds `ready` low until the access completes. The hazard/freeze logic uses `ready` to stall every pipeline stage.

## Interface
- `WAIT_CYCLES`, 2: clock cycles each halfword access is held on the SRAM bus; legal range 1..15.
- `SRAM_AW`, 18: SRAM halfword address width.

- `clk` in 1: system clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `MEM_R_EN` in 1: read request from MEM stage.
- `MEM_W_EN` in 1: write request from MEM stage.
- `addr` in 32: byte address; word index = `addr[SRAM_AW:2]`, `addr[1:0]` ignored.
- `Val_RM` in 32: write data.
- `data_mem` out 32: read data.
- `ready` out 1: high = no access pending or access finishing this cycle; low = stall pipeline.
- `sram_addr` out SRAM_AW: halfword address.
- `sram_wdata` out 16: halfword write data.
- `sram_rdata` in 16: halfword read data from pad.
- `sram_we_n` out 1: SRAM write strobe, active-low.
- `sram_drive` out 1: enables the external tri-state driver for `sram_wdata`.

## Operation
- States: IDLE, LO, HI, DONE. There is a wait counter `cnt` of 4 bits.
- IDLE:
  - If `MEM_W_EN` is high, latch `addr`, `Val_RM` and op=write, then go to LO.
  - Else if `MEM_R_EN` is high, latch `addr` and op=read, then go to LO.
  - Else stay in IDLE.
  - Write wins when both requests are high; the read is dropped and no error is raised.
- LO:
  - `sram_addr` = {word index, 1'b0}.
  - Write: `sram_wdata` = latched data[15:0].
  - Stay for WAIT_CYCLES cycles (`cnt` counts 0..WAIT_CYCLES-1), then go to HI with `cnt` cleared.
- HI:
  - `sram_addr` = {word index, 1'b1}.
  - Write: `sram_wdata` = latched data[31:16].
  - Stay for WAIT_CYCLES cycles, then go to DONE.
- DONE: lasts one cycle, then returns to IDLE unconditionally.
- Read capture:
  - `data_mem[15:0]` captures `sram_rdata` on the last LO cycle.
  - `data_mem[31:16]` captures `sram_rdata` on the last HI cycle.
  - Between reads, `data_mem` holds the last completed read value; writes leave it unchanged.
- `sram_we_n` = 0 throughout LO and HI of a write; 1 in all other cases.
- `sram_drive` follows `!sram_we_n`.
- In IDLE and DONE, `sram_addr` and `sram_wdata` hold their last values. They change only on the LO/HI transitions.
- `ready` (combinational):
  - 1 in DONE.
  - 1 in IDLE when neither request is high.
  - 0 in IDLE with a request, and in LO and HI.
- Requests must be held stable by the pipeline until `ready` is high. The controller uses only the values latched at IDLE.
- Back-to-back requests: the pipeline advances on the DONE cycle, so a request present in the following IDLE is a new access and starts immediately.

## Timing
- Reset values: state IDLE, `cnt` 0, `data_mem` 0, `sram_addr` 0, `sram_wdata` 0, `sram_we_n` 1, `sram_drive` 0.
- `ready` = 1 out of reset while requests are low.
- Stall length for a request first seen in IDLE at cycle 0:
  - `ready` is 0 for cycles 0..2·WAIT_CYCLES.
  - `ready` is 1 at cycle 2·WAIT_CYCLES+1 (DONE).
  - Default: 5 stall cycles, `ready` high at cycle 5.
- Read data: `data_mem` is valid from the DONE cycle onward, i.e. the same cycle `ready` rises.
- Request sustain: a request held high continuously yields one access every 2·WAIT_CYCLES+2 cycles.
- Reset mid-access:
  - Immediately returns to IDLE.
  - `sram_we_n` goes to 1 and `sram_drive` to 0 in the same cycle `rst` rises, with no clock edge required.
  - No partial write completion is guaranteed.
- A request that drops during LO/HI is a protocol violation. The access still completes and `ready` still pulses.

## Test plan
- Reset idle: assert `rst` with no requests, then release. Required: `ready`=1, `sram_we_n`=1, `sram_drive`=0, `data_mem`=0, and the state stays IDLE for 10 cycles.
- Write word: `MEM_W_EN`=1, `addr`=0x0000_0008, `Val_RM`=0xDEAD_BEEF. Required:
  - `sram_addr`=4 with `sram_wdata`=0xBEEF for 2 cycles.
  - Then `sram_addr`=5 with `sram_wdata`=0xDEAD for 2 cycles, `sram_we_n`=0 for all 4 cycles.
  - `ready`=0 on cycles 0–4 and 1 on cycle 5.
- Read-back: the SRAM model holds the previous write. `MEM_R_EN`=1, `addr`=0x8. Required: `sram_we_n` stays 1, and `data_mem`=0xDEAD_BEEF when `ready` rises at cycle 5.
- Simultaneous requests: `MEM_R_EN`=`MEM_W_EN`=1, `addr`=0xC, `Val_RM`=0x1234_5678. Required: a write is performed (halfwords 0x5678 then 0x1234 at addresses 6/7), and `data_mem` keeps its prior value.
- Back-to-back: write 0xA5A5_0001 to 0x10, then immediately read 0x10. Required: the read's LO state starts the cycle after DONE, and `data_mem`=0xA5A5_0001 at cycle 11.
- Reset mid-write: assert `rst` in the second HI cycle. Required: `sram_we_n`=1 and `sram_drive`=0 asynchronously, and `ready`=1 after release.
- Optional parameter sweep: rerun the write test with WAIT_CYCLES=1. Required: `ready` rises at cycle 3.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: MEM-stage to 16-bit async SRAM sequencer.
// Each 32-bit access is split into two timed halfword accesses.
module mem_ctrl #(
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [31:0]        addr,
  input  logic [31:0]        Val_RM,
  output logic [31:0]        data_mem,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_wdata,
  input  logic [15:0]        sram_rdata,
  output logic               sram_we_n,
  output logic               sram_drive
);

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t             state;
  state_t             state_nxt;
  logic [3:0]         cnt;
  logic [3:0]         cnt_nxt;
  logic               op_wr;
  logic [SRAM_AW-2:0] idx;
  logic [15:0]        wdat_hi;
  logic               req;
  logic               start;
  logic               last;
  logic               unused;

  assign req    = MEM_W_EN | MEM_R_EN;
  assign start  = (state == IDLE) && req;
  assign last   = (cnt == LAST);
  assign unused = ^{addr[31:SRAM_AW+1], addr[1:0]};

  // State and wait-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state, counter and ready decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready     = 1'b0;
    unique case (state)
      IDLE: begin
        ready = !req;
        if (req) begin
          state_nxt = LO;
          cnt_nxt   = '0;
        end
      end
      LO: begin
        if (last) begin
          state_nxt = HI;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      HI: begin
        if (last) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Latch the request; write wins when both are raised.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_wr   <= 1'b0;
      idx     <= '0;
      wdat_hi <= '0;
    end else if (start) begin
      op_wr <= MEM_W_EN;
      idx   <= addr[SRAM_AW:2];
      if (MEM_W_EN) wdat_hi <= Val_RM[31:16];
    end
  end

  // SRAM bus registers; they move only when entering LO or HI.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else if (start) begin
      sram_addr <= {addr[SRAM_AW:2], 1'b0};
      if (MEM_W_EN) sram_wdata <= Val_RM[15:0];
    end else if (state == LO && last) begin
      sram_addr <= {idx, 1'b1};
      if (op_wr) sram_wdata <= wdat_hi;
    end
  end

  // Read capture on the final cycle of each halfword.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_mem <= '0;
    end else if (!op_wr && last) begin
      if (state == LO) data_mem[15:0]  <= sram_rdata;
      if (state == HI) data_mem[31:16] <= sram_rdata;
    end
  end

  // Strobe decodes from state so reset releases it without a clock.
  assign sram_we_n  = !(op_wr && (state == LO || state == HI));
  assign sram_drive = !sram_we_n;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed plus randomized checks of mem_ctrl
// against a word-level memory model.
module tb_mem_ctrl;

  localparam int W  = 2;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          MEM_R_EN;
  logic          MEM_W_EN;
  logic [31:0]   addr;
  logic [31:0]   Val_RM;
  logic [31:0]   data_mem;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_wdata;
  logic [15:0]   sram_rdata;
  logic          sram_we_n;
  logic          sram_drive;

  int checks = 0;
  int errors = 0;

  logic [15:0] sram [0:127];
  logic [31:0] ref_mem [0:63];
  logic [31:0] exp_data;

  mem_ctrl #(
    .WAIT_CYCLES(W),
    .SRAM_AW(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .MEM_R_EN(MEM_R_EN),
    .MEM_W_EN(MEM_W_EN),
    .addr(addr),
    .Val_RM(Val_RM),
    .data_mem(data_mem),
    .ready(ready),
    .sram_addr(sram_addr),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata),
    .sram_we_n(sram_we_n),
    .sram_drive(sram_drive)
  );

  always #5 clk = ~clk;

  assign sram_rdata = sram[sram_addr[6:0]];

  always @(posedge clk)
    if (!sram_we_n) sram[sram_addr[6:0]] <= sram_wdata;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge with the controller idle.
  task automatic access(input logic w, input logic r,
                        input logic [31:0] a, input logic [31:0] d);
    int n = 2 * W;
    logic [31:0] lo_a;
    logic [31:0] hi_a;
    lo_a = 32'(a[AW:2]) * 2;
    hi_a = lo_a + 1;
    MEM_W_EN = w;
    MEM_R_EN = r;
    addr     = a;
    Val_RM   = d;
    if (w) ref_mem[a[7:2]] = d;
    else   exp_data = ref_mem[a[7:2]];
    for (int c = 0; c <= n + 1; c++) begin
      @(negedge clk);
      check($sformatf("ready c%0d a%h", c, a),
            32'(ready), 32'(c == n + 1));
      if (c >= 1 && c <= n) begin
        check($sformatf("we_n c%0d", c), 32'(sram_we_n), 32'(!w));
        check($sformatf("addr c%0d", c), 32'(sram_addr),
              (c <= W) ? lo_a : hi_a);
        if (w)
          check($sformatf("wdata c%0d", c), 32'(sram_wdata),
                (c <= W) ? 32'(d[15:0]) : 32'(d[31:16]));
      end else begin
        check($sformatf("we_n c%0d", c), 32'(sram_we_n), 32'd1);
      end
      check($sformatf("drive c%0d", c), 32'(sram_drive),
            32'(!sram_we_n));
    end
    check($sformatf("data_mem a%h", a), data_mem, exp_data);
    check("addr hold in DONE", 32'(sram_addr), hi_a);
    @(posedge clk);
    #1;
    MEM_W_EN = 1'b0;
    MEM_R_EN = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) sram[i] = 16'h0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    exp_data = 32'h0;
    rst      = 1'b1;
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    addr     = 32'h0;
    Val_RM   = 32'h0;

    repeat (2) @(negedge clk);
    check("rst ready", 32'(ready), 32'd1);
    check("rst we_n", 32'(sram_we_n), 32'd1);
    check("rst drive", 32'(sram_drive), 32'd0);
    check("rst data_mem", data_mem, 32'h0);
    check("rst sram_addr", 32'(sram_addr), 32'h0);
    check("rst sram_wdata", 32'(sram_wdata), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("idle ready %0d", i), 32'(ready), 32'd1);
      check($sformatf("idle we_n %0d", i), 32'(sram_we_n), 32'd1);
    end
    @(posedge clk);
    #1;

    access(1'b1, 1'b0, 32'h0000_0008, 32'hDEAD_BEEF);
    access(1'b0, 1'b1, 32'h0000_0008, 32'h0);
    check("readback", data_mem, 32'hDEAD_BEEF);
    access(1'b1, 1'b1, 32'h0000_000C, 32'h1234_5678);
    check("both keeps data", data_mem, 32'hDEAD_BEEF);
    access(1'b0, 1'b1, 32'h0000_000C, 32'h0);
    check("both wrote", data_mem, 32'h1234_5678);
    access(1'b1, 1'b0, 32'h0000_0010, 32'hA5A5_0001);
    access(1'b0, 1'b1, 32'h0000_0010, 32'h0);
    check("b2b read", data_mem, 32'hA5A5_0001);

    MEM_W_EN = 1'b1;
    addr     = 32'h0000_00FC;
    Val_RM   = 32'hCAFE_F00D;
    for (int c = 0; c <= 2 * W; c++) @(negedge clk);
    check("mid we_n before", 32'(sram_we_n), 32'd0);
    #1;
    rst = 1'b1;
    #1;
    check("mid rst we_n", 32'(sram_we_n), 32'd1);
    check("mid rst drive", 32'(sram_drive), 32'd0);
    MEM_W_EN = 1'b0;
    #1;
    check("mid rst ready", 32'(ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_data = 32'h0;
    @(negedge clk);
    check("post rst ready", 32'(ready), 32'd1);
    check("post rst data", data_mem, 32'h0);
    @(posedge clk);
    #1;

    for (int k = 0; k < 40; k++) begin
      int op;
      int gap;
      logic [31:0] a;
      op  = $urandom_range(0, 2);
      gap = $urandom_range(0, 2);
      a   = {24'h0, 6'($urandom_range(0, 62)), 2'($urandom)};
      access(op != 1, op != 0, a, $urandom);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        check($sformatf("gap ready %0d", k), 32'(ready), 32'd1);
        @(posedge clk);
        #1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
